csr_unit: RTL and testbench

Parametrised LoongArch control/status register file for the CALab pipeline; successor to the fixed CRMD/PRMD/ECFG/ESTAT/ERA/EENTRY/SAVE block. It adds a configurable count of SAVE registers and hardware interrupt lines, a BADV capture path, and a TID/TCFG/TVAL/TICLR countdown timer with one-shot and periodic modes. Instruction access (csrrd/csrwr/csrxchg) comes from ID/WB; exception and ertn events come from WB. Entry and return PCs and the interrupt request go to pre-IF and ID.

---
 rtl/csr_unit_if.sv | 19 +
 rtl/csr_unit.sv | 250 +++++++++++++++++++++++++
 tb/tb_csr_unit.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_unit_if.sv
// Instruction-side CSR access bus: csrrd/csrwr/csrxchg number, mask, data and combinational read-back.
interface csr_unit_if;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;

    modport master (
        output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
        input  csr_rvalue
    );

    modport slave (
        input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
        output csr_rvalue
    );
endinterface

// File: rtl/csr_unit.sv
// LoongArch CSR file: CRMD/PRMD/ECFG/ESTAT/ERA/BADV/EENTRY/SAVEn/TID with exception and ertn updates.
// Define CSR_TIMER_EN to add TCFG/TVAL/TICLR and the countdown timer driving ESTAT.IS[11].
module csr_unit #(
    parameter int          SAVE_NUM    = 4,
    parameter int          HW_INT_NUM  = 8,
    parameter int          TIMER_W     = 32,
    parameter logic [31:0] TID_INIT    = 32'h0,
    parameter logic [31:0] EENTRY_INIT = 32'h1c008000
) (
    input  logic                  clk,
    input  logic                  rst,
    csr_unit_if.slave             bus,
    input  logic [HW_INT_NUM-1:0] hw_int_in,
    input  logic                  ipi_int_in,
    input  logic                  wb_ex,
    input  logic [5:0]            wb_ecode,
    input  logic [8:0]            wb_esubcode,
    input  logic [31:0]           wb_pc,
    input  logic [31:0]           wb_vaddr,
    input  logic                  ertn_flush,
    output logic [31:0]           ex_entry,
    output logic [31:0]           ertn_pc,
    output logic                  has_int
);

    localparam logic [13:0] CSR_CRMD   = 14'h00;
    localparam logic [13:0] CSR_PRMD   = 14'h01;
    localparam logic [13:0] CSR_ECFG   = 14'h04;
    localparam logic [13:0] CSR_ESTAT  = 14'h05;
    localparam logic [13:0] CSR_ERA    = 14'h06;
    localparam logic [13:0] CSR_BADV   = 14'h07;
    localparam logic [13:0] CSR_EENTRY = 14'h0c;
    localparam logic [13:0] CSR_TID    = 14'h40;
    localparam int          CSR_SAVE0  = 'h30;
    localparam logic [12:0] LIE_MASK   = 13'h1bff;

    function automatic logic [31:0] mw(input logic [31:0] old, input logic [31:0] mask,
                                       input logic [31:0] val);
        return (mask & val) | (~mask & old);
    endfunction

    logic [1:0]            crmd_plv;
    logic                  crmd_ie;
    logic [1:0]            prmd_pplv;
    logic                  prmd_pie;
    logic [12:0]           ecfg_lie;
    logic [1:0]            is_sw;
    logic [HW_INT_NUM-1:0] hw_is;
    logic                  ipi_is;
    logic                  ti_is;
    logic [5:0]            estat_ecode;
    logic [8:0]            estat_esub;
    logic [31:0]           era;
    logic [31:0]           badv;
    logic [25:0]           eentry_va;
    logic [31:0]           tid;
    logic [31:0]           save_q [SAVE_NUM];

    logic [7:0]  hw_ext;
    logic [12:0] is_vec;
    logic [31:0] crmd_rd, prmd_rd, ecfg_rd, estat_rd, eentry_rd;
    logic [31:0] rd_data;

    logic wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv, wr_eentry, wr_tid;
    logic badv_capture;

    assign wr_crmd   = bus.csr_we && (bus.csr_num == CSR_CRMD);
    assign wr_prmd   = bus.csr_we && (bus.csr_num == CSR_PRMD);
    assign wr_ecfg   = bus.csr_we && (bus.csr_num == CSR_ECFG);
    assign wr_estat  = bus.csr_we && (bus.csr_num == CSR_ESTAT);
    assign wr_era    = bus.csr_we && (bus.csr_num == CSR_ERA);
    assign wr_badv   = bus.csr_we && (bus.csr_num == CSR_BADV);
    assign wr_eentry = bus.csr_we && (bus.csr_num == CSR_EENTRY);
    assign wr_tid    = bus.csr_we && (bus.csr_num == CSR_TID);

    // Only address-class exceptions (ADE/ALE) carry a meaningful bad address.
    assign badv_capture = wb_ex && ((wb_ecode == 6'h08) || (wb_ecode == 6'h09));

    always_comb begin
        hw_ext = '0;
        hw_ext[HW_INT_NUM-1:0] = hw_is;
    end

    assign is_vec    = {ipi_is, ti_is, 1'b0, hw_ext, is_sw};
    assign crmd_rd   = {23'b0, 4'b0, 1'b0, 1'b1, crmd_ie, crmd_plv};
    assign prmd_rd   = {29'b0, prmd_pie, prmd_pplv};
    assign ecfg_rd   = {19'b0, ecfg_lie};
    assign estat_rd  = {1'b0, estat_esub, estat_ecode, 3'b0, is_vec};
    assign eentry_rd = {eentry_va, 6'b0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crmd_plv  <= 2'b0;
            crmd_ie   <= 1'b0;
            prmd_pplv <= 2'b0;
            prmd_pie  <= 1'b0;
        end else begin
            if (wb_ex) begin
                crmd_plv <= 2'b0;
                crmd_ie  <= 1'b0;
            end else if (ertn_flush) begin
                crmd_plv <= prmd_pplv;
                crmd_ie  <= prmd_pie;
            end else if (wr_crmd) begin
                crmd_plv <= mw(crmd_rd, bus.csr_wmask, bus.csr_wvalue)[1:0];
                crmd_ie  <= mw(crmd_rd, bus.csr_wmask, bus.csr_wvalue)[2];
            end
            if (wb_ex) begin
                prmd_pplv <= crmd_plv;
                prmd_pie  <= crmd_ie;
            end else if (wr_prmd) begin
                prmd_pplv <= mw(prmd_rd, bus.csr_wmask, bus.csr_wvalue)[1:0];
                prmd_pie  <= mw(prmd_rd, bus.csr_wmask, bus.csr_wvalue)[2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ecfg_lie    <= '0;
            is_sw       <= '0;
            hw_is       <= '0;
            ipi_is      <= 1'b0;
            estat_ecode <= '0;
            estat_esub  <= '0;
        end else begin
            if (wr_ecfg)
                ecfg_lie <= mw(ecfg_rd, bus.csr_wmask, bus.csr_wvalue)[12:0] & LIE_MASK;
            if (wr_estat)
                is_sw <= mw(estat_rd, bus.csr_wmask, bus.csr_wvalue)[1:0];
            hw_is  <= hw_int_in;
            ipi_is <= ipi_int_in;
            if (wb_ex) begin
                estat_ecode <= wb_ecode;
                estat_esub  <= wb_esubcode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            era       <= '0;
            badv      <= '0;
            eentry_va <= EENTRY_INIT[31:6];
            tid       <= TID_INIT;
            for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= '0;
        end else begin
            if (wb_ex)
                era <= wb_pc;
            else if (wr_era)
                era <= mw(era, bus.csr_wmask, bus.csr_wvalue);
            if (badv_capture)
                badv <= wb_vaddr;
            else if (wr_badv)
                badv <= mw(badv, bus.csr_wmask, bus.csr_wvalue);
            if (wr_eentry)
                eentry_va <= mw(eentry_rd, bus.csr_wmask, bus.csr_wvalue)[31:6];
            if (wr_tid)
                tid <= mw(tid, bus.csr_wmask, bus.csr_wvalue);
            for (int i = 0; i < SAVE_NUM; i++)
                if (bus.csr_we && (bus.csr_num == 14'(CSR_SAVE0 + i)))
                    save_q[i] <= mw(save_q[i], bus.csr_wmask, bus.csr_wvalue);
        end
    end

`ifdef CSR_TIMER_EN
    localparam logic [13:0] CSR_TCFG  = 14'h41;
    localparam logic [13:0] CSR_TVAL  = 14'h42;
    localparam logic [13:0] CSR_TICLR = 14'h44;

    logic               tcfg_en;
    logic               tcfg_per;
    logic [TIMER_W-3:0] tcfg_init;
    logic [TIMER_W-1:0] cnt;
    logic [31:0]        tcfg_rd, tcfg_nx, tval_rd;
    logic               wr_tcfg, ticlr_clr, cnt_zero, cnt_idle, fire;

    always_comb begin
        tcfg_rd = '0;
        tcfg_rd[TIMER_W-1:2] = tcfg_init;
        tcfg_rd[1] = tcfg_per;
        tcfg_rd[0] = tcfg_en;
        tval_rd = '0;
        tval_rd[TIMER_W-1:0] = cnt;
    end

    assign tcfg_nx   = mw(tcfg_rd, bus.csr_wmask, bus.csr_wvalue);
    assign wr_tcfg   = bus.csr_we && (bus.csr_num == CSR_TCFG);
    assign ticlr_clr = bus.csr_we && (bus.csr_num == CSR_TICLR)
                       && bus.csr_wmask[0] && bus.csr_wvalue[0];
    assign cnt_zero  = (cnt == '0);
    // All-ones marks an expired one-shot timer that must not keep counting.
    assign cnt_idle  = &cnt;
    assign fire      = tcfg_en && cnt_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcfg_en   <= 1'b0;
            tcfg_per  <= 1'b0;
            tcfg_init <= '0;
            cnt       <= '1;
            ti_is     <= 1'b0;
        end else begin
            if (wr_tcfg) begin
                tcfg_en   <= tcfg_nx[0];
                tcfg_per  <= tcfg_nx[1];
                tcfg_init <= tcfg_nx[TIMER_W-1:2];
            end
            if (wr_tcfg && tcfg_nx[0])
                cnt <= {tcfg_nx[TIMER_W-1:2], 2'b00};
            else if (tcfg_en && !cnt_idle)
                cnt <= (cnt_zero && tcfg_per) ? {tcfg_init, 2'b00} : cnt - 1'b1;
            if (fire)
                ti_is <= 1'b1;
            else if (ticlr_clr)
                ti_is <= 1'b0;
        end
    end
`else
    assign ti_is = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        case (bus.csr_num)
            CSR_CRMD:   rd_data = crmd_rd;
            CSR_PRMD:   rd_data = prmd_rd;
            CSR_ECFG:   rd_data = ecfg_rd;
            CSR_ESTAT:  rd_data = estat_rd;
            CSR_ERA:    rd_data = era;
            CSR_BADV:   rd_data = badv;
            CSR_EENTRY: rd_data = eentry_rd;
            CSR_TID:    rd_data = tid;
`ifdef CSR_TIMER_EN
            CSR_TCFG:   rd_data = tcfg_rd;
            CSR_TVAL:   rd_data = tval_rd;
`endif
            default:    rd_data = '0;
        endcase
        for (int i = 0; i < SAVE_NUM; i++)
            if (bus.csr_num == 14'(CSR_SAVE0 + i))
                rd_data = save_q[i];
    end

    assign bus.csr_rvalue = bus.csr_re ? rd_data : 32'h0;
    assign ex_entry       = eentry_rd;
    assign ertn_pc        = era;
    assign has_int        = crmd_ie && (|(is_vec & ecfg_lie));

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios plus randomized traffic against a word-level model.
module tb_csr_unit;
    localparam int          SAVE_NUM    = 4;
    localparam logic [31:0] TID_INIT    = 32'h0;
    localparam logic [31:0] EENTRY_INIT = 32'h1c008000;
`ifdef CSR_TIMER_EN
    localparam logic [31:0] TVAL_RST = 32'hffffffff;
`else
    localparam logic [31:0] TVAL_RST = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in, wb_ex, ertn_flush;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, wb_vaddr, ex_entry, ertn_pc;
    logic        has_int;
    int          n_cmp = 0;
    int          n_bad = 0;

    csr_unit_if bus();

    csr_unit #(.SAVE_NUM(SAVE_NUM), .HW_INT_NUM(8), .TIMER_W(32),
               .TID_INIT(TID_INIT), .EENTRY_INIT(EENTRY_INIT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .ex_entry(ex_entry),
        .ertn_pc(ertn_pc), .has_int(has_int)
    );

    always #5 clk = ~clk;

    // Architectural model: each CSR held as the 32-bit word software would read.
    logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_badv, m_eentry, m_tid, m_tcfg, m_cnt;
    logic [31:0] m_save [SAVE_NUM];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [13:0] num);
        if (num >= 14'h30 && num < 14'(32'h30 + SAVE_NUM)) return m_save[num - 14'h30];
        case (num)
            14'h00: return m_crmd;
            14'h01: return m_prmd;
            14'h04: return m_ecfg;
            14'h05: return m_estat;
            14'h06: return m_era;
            14'h07: return m_badv;
            14'h0c: return m_eentry;
            14'h40: return m_tid;
`ifdef CSR_TIMER_EN
            14'h41: return m_tcfg;
            14'h42: return m_cnt;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_has_int();
        return m_crmd[2] && ((m_estat & m_ecfg & 32'h1fff) != 0);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old);
        return (old & ~bus.csr_wmask) | (bus.csr_wvalue & bus.csr_wmask);
    endfunction

    function automatic logic wr(input logic [13:0] num);
        return bus.csr_we && bus.csr_num == num;
    endfunction

    task automatic model_reset();
        m_crmd = 32'h8; m_prmd = 0; m_ecfg = 0; m_estat = 0; m_era = 0; m_badv = 0;
        m_eentry = EENTRY_INIT; m_tid = TID_INIT; m_tcfg = 0; m_cnt = 32'hffffffff;
        for (int i = 0; i < SAVE_NUM; i++) m_save[i] = 0;
    endtask

    task automatic model_step();
        logic [31:0] n_crmd, n_prmd, n_tcfg, n_cnt, t;
        logic [1:0]  sw;
        logic [14:0] exc;
        logic        ti;
        n_crmd = m_crmd;
        if (wb_ex) n_crmd = m_crmd & ~32'h7;
        else if (ertn_flush) n_crmd = (m_crmd & ~32'h7) | (m_prmd & 32'h7);
        else if (wr(14'h00)) n_crmd = (m_crmd & ~32'h7) | (merge(m_crmd) & 32'h7);
        n_prmd = m_prmd;
        if (wb_ex) n_prmd = m_crmd & 32'h7;
        else if (wr(14'h01)) n_prmd = merge(m_prmd) & 32'h7;
        if (wr(14'h04)) m_ecfg = merge(m_ecfg) & 32'h1bff;
        t  = merge(m_estat);
        sw = wr(14'h05) ? t[1:0] : m_estat[1:0];
        ti = m_estat[11];
        exc = wb_ex ? {wb_esubcode, wb_ecode} : m_estat[30:16];
        if (wb_ex) m_era = wb_pc; else if (wr(14'h06)) m_era = merge(m_era);
        if (wb_ex && (wb_ecode == 6'h08 || wb_ecode == 6'h09)) m_badv = wb_vaddr;
        else if (wr(14'h07)) m_badv = merge(m_badv);
        if (wr(14'h0c)) m_eentry = merge(m_eentry) & ~32'h3f;
        if (wr(14'h40)) m_tid = merge(m_tid);
        for (int i = 0; i < SAVE_NUM; i++)
            if (wr(14'(32'h30 + i))) m_save[i] = merge(m_save[i]);
`ifdef CSR_TIMER_EN
        n_tcfg = wr(14'h41) ? merge(m_tcfg) : m_tcfg;
        n_cnt  = m_cnt;
        if (wr(14'h41) && n_tcfg[0]) n_cnt = n_tcfg & ~32'h3;
        else if (m_tcfg[0] && m_cnt != 32'hffffffff)
            n_cnt = (m_cnt == 0) ? (m_tcfg[1] ? (m_tcfg & ~32'h3) : 32'hffffffff) : m_cnt - 1;
        if (m_tcfg[0] && m_cnt == 0) ti = 1'b1;
        else if (wr(14'h44) && bus.csr_wmask[0] && bus.csr_wvalue[0]) ti = 1'b0;
        m_tcfg = n_tcfg;
        m_cnt  = n_cnt;
`endif
        m_estat = {1'b0, exc, 3'b0, ipi_int_in, ti, 1'b0, hw_int_in, sw};
        m_crmd  = n_crmd;
        m_prmd  = n_prmd;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset(); else model_step();
        #1;
    endtask

    task automatic wr_csr(input logic [13:0] num, input logic [31:0] val, input logic [31:0] mask);
        bus.csr_we = 1'b1; bus.csr_num = num; bus.csr_wvalue = val; bus.csr_wmask = mask;
        tick();
        bus.csr_we = 1'b0;
    endtask

    task automatic peek(input logic [13:0] num, output logic [31:0] v);
        bus.csr_re = 1'b1; bus.csr_num = num;
        #1;
        v = bus.csr_rvalue;
        bus.csr_re = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [13:0] num, input logic [31:0] exp);
        logic [31:0] v;
        peek(num, v);
        check(tag, v, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [13:0] nums [18] = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0c,
                                   14'h30, 14'h31, 14'h32, 14'h33, 14'h34, 14'h40, 14'h41,
                                   14'h42, 14'h44, 14'h02, 14'h3fff};
        rst = 1'b0;
        bus.csr_re = 0; bus.csr_we = 0; bus.csr_num = 0; bus.csr_wmask = 0; bus.csr_wvalue = 0;
        hw_int_in = 0; ipi_int_in = 0; wb_ex = 0; ertn_flush = 0;
        wb_ecode = 0; wb_esubcode = 0; wb_pc = 0; wb_vaddr = 0;
        model_reset();
        repeat (3) tick();
        rst = 1'b1;

        rd_chk("rst_crmd", 14'h00, 32'h8);
        rd_chk("rst_ecfg", 14'h04, 32'h0);
        rd_chk("rst_eentry", 14'h0c, 32'h1c008000);
        rd_chk("rst_tval", 14'h42, TVAL_RST);
        check("rst_has_int", 32'(has_int), 32'h0);
        check("rst_ex_entry", ex_entry, 32'h1c008000);
        check("rst_ertn_pc", ertn_pc, 32'h0);

        wr_csr(14'h00, 32'h7, 32'h4);
        rd_chk("crmd_xchg", 14'h00, 32'hc);
        wb_ex = 1; wb_pc = 32'h1c000100; wb_ecode = 6'h09; wb_esubcode = 0; wb_vaddr = 32'h3;
        tick();
        wb_ex = 0;
        rd_chk("ex_crmd", 14'h00, 32'h8);
        rd_chk("ex_prmd", 14'h01, 32'h4);
        rd_chk("ex_era", 14'h06, 32'h1c000100);
        rd_chk("ex_badv", 14'h07, 32'h3);
        peek(14'h05, v);
        check("ex_ecode", 32'(v[21:16]), 32'h9);
        check("ex_ertn_pc", ertn_pc, 32'h1c000100);
        ertn_flush = 1;
        tick();
        ertn_flush = 0;
        rd_chk("ertn_crmd", 14'h00, 32'hc);
        check("ertn_ex_entry", ex_entry, 32'h1c008000);

        wr_csr(14'h04, 32'h1fff, 32'hffffffff);
        rd_chk("ecfg_mask", 14'h04, 32'h1bff);
        wr_csr(14'h05, 32'h1, 32'h3);
        check("swint_has_int", 32'(has_int), 32'h1);
        wr_csr(14'h00, 32'h0, 32'h4);
        check("ie_off_has_int", 32'(has_int), 32'h0);
        wr_csr(14'h05, 32'h0, 32'h3);

        wr_csr(14'h04, 32'h20, 32'hffffffff);
        wr_csr(14'h00, 32'h4, 32'h4);
        hw_int_in = 8'h08;
        #1;
        check("hw_pre_has_int", 32'(has_int), 32'h0);
        tick();
        peek(14'h05, v);
        check("hw_is5", 32'(v[5]), 32'h1);
        check("hw_has_int", 32'(has_int), 32'h1);
        hw_int_in = 8'h00;
        tick();
        check("hw_drop_has_int", 32'(has_int), 32'h0);

        wr_csr(14'h33, 32'hdeadbeef, 32'hffffffff);
        rd_chk("save3", 14'h33, 32'hdeadbeef);
        rd_chk("save_oob", 14'h34, 32'h0);
        bus.csr_re = 0; bus.csr_num = 14'h33;
        #1;
        check("re_low", bus.csr_rvalue, 32'h0);

`ifdef CSR_TIMER_EN
        wr_csr(14'h41, 32'h0b, 32'hffffffff);
        rd_chk("tval_load", 14'h42, 32'h8);
        for (int k = 7; k >= 0; k--) begin
            tick();
            rd_chk("tval_dec", 14'h42, 32'(k));
        end
        peek(14'h05, v);
        check("ti_before", 32'(v[11]), 32'h0);
        tick();
        peek(14'h05, v);
        check("ti_fire", 32'(v[11]), 32'h1);
        rd_chk("tval_reload", 14'h42, 32'h8);
        wr_csr(14'h44, 32'h1, 32'h1);
        peek(14'h05, v);
        check("ticlr", 32'(v[11]), 32'h0);
        repeat (7) tick();
        rd_chk("tval_zero", 14'h42, 32'h0);
        wr_csr(14'h44, 32'h1, 32'h1);
        peek(14'h05, v);
        check("ticlr_vs_set", 32'(v[11]), 32'h1);
        wr_csr(14'h44, 32'h1, 32'h1);
        wr_csr(14'h41, 32'h09, 32'hffffffff);
        repeat (8) tick();
        peek(14'h05, v);
        check("os_before", 32'(v[11]), 32'h0);
        tick();
        peek(14'h05, v);
        check("os_fire", 32'(v[11]), 32'h1);
        rd_chk("os_tval", 14'h42, 32'hffffffff);
        wr_csr(14'h44, 32'h1, 32'h1);
        repeat (20) tick();
        peek(14'h05, v);
        check("os_once", 32'(v[11]), 32'h0);
        rd_chk("os_hold", 14'h42, 32'hffffffff);
`else
        wr_csr(14'h41, 32'h0b, 32'hffffffff);
        rd_chk("tcfg_unmapped", 14'h41, 32'h0);
        repeat (12) tick();
        rd_chk("tval_unmapped", 14'h42, 32'h0);
        peek(14'h05, v);
        check("ti_const", 32'(v[11]), 32'h0);
`endif
        for (int i = 0; i < 18; i++) rd_chk("sync", nums[i], model_read(nums[i]));

        for (int n = 0; n < 3000; n++) begin
            bus.csr_num    = nums[$urandom_range(0, 17)];
            bus.csr_re     = ($urandom_range(0, 3) != 0);
            bus.csr_we     = ($urandom_range(0, 2) == 0);
            bus.csr_wmask  = ($urandom_range(0, 1) == 1) ? 32'hffffffff : $urandom;
            bus.csr_wvalue = (bus.csr_num == 14'h41) ? $urandom_range(0, 63) : $urandom;
            wb_ex       = ($urandom_range(0, 15) == 0);
            ertn_flush  = ($urandom_range(0, 15) == 0);
            wb_ecode    = 6'($urandom_range(0, 15));
            wb_esubcode = 9'($urandom);
            wb_pc       = $urandom;
            wb_vaddr    = $urandom;
            hw_int_in   = 8'($urandom);
            ipi_int_in  = 1'($urandom);
            #1;
            check("rnd_rvalue", bus.csr_rvalue, bus.csr_re ? model_read(bus.csr_num) : 32'h0);
            check("rnd_has_int", 32'(has_int), 32'(model_has_int()));
            check("rnd_ex_entry", ex_entry, m_eentry);
            check("rnd_ertn_pc", ertn_pc, m_era);
            if (n == 1500) begin
                rst = 1'b0;
                #1;
                model_reset();
                check("arst_ex_entry", ex_entry, 32'h1c008000);
                check("arst_ertn_pc", ertn_pc, 32'h0);
                check("arst_has_int", 32'(has_int), 32'h0);
                bus.csr_we = 0;
                rd_chk("arst_crmd", 14'h00, 32'h8);
                rd_chk("arst_tval", 14'h42, TVAL_RST);
                tick();
                rst = 1'b1;
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
